load_align_unit: RTL

// Memory-stage load unit. Accepts one load from execute and issues a word-aligned read on the

---
 rtl/load_align_unit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/load_align_unit.sv
// load_align_unit: issues one word-aligned data-memory read per load and right-aligns the addressed byte/halfword/word.
// Optional LSU_TIMEOUT_EN aborts a load after TIMEOUT_CYCLES in REQ+WAIT with an error result.
module load_align_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [2:0]            ld_funct3,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] unextended_data,
    output logic [2:0]            sx_op,
    output logic                  res_err
);
    // Local copy of the isa_shared signext opcodes.
    localparam logic [2:0] SX_0700 = 3'd0, SX_1500 = 3'd1, SX_3100 = 3'd2;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            f3_q, f3_d, sx_q, sx_d, ext_sx;
    logic [DATA_WIDTH-1:0] data_q, data_d, ext;
    logic                  err_q, err_d, bad;
    logic [7:0]            b;
    logic [15:0]           h;
`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif
    assign bad = !(ld_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
               || (ld_funct3[1:0] == 2'b01 && ld_addr[0])
               || (ld_funct3 == 3'b010 && ld_addr[1:0] != 2'b00);
    assign b      = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign h      = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    // Only legal funct3 values reach WAIT, so bit decoding is sufficient.
    assign ext    = f3_q[1] ? mem_rdata : f3_q[0] ? {{(DATA_WIDTH-16){1'b0}}, h} : {{(DATA_WIDTH-8){1'b0}}, b};
    assign ext_sx = (f3_q[2] | f3_q[1]) ? SX_3100 : f3_q[0] ? SX_1500 : SX_0700;
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        data_d  = data_q;
        sx_d    = sx_q;
        err_d   = err_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: if (ld_valid) begin
                addr_d = ld_addr;
                f3_d   = ld_funct3;
`ifdef LSU_TIMEOUT_EN
                cnt_d  = '0;
`endif
                if (bad) begin
                    state_d = RESP;
                    data_d  = '0;
                    sx_d    = SX_3100;
                    err_d   = 1'b1;
                end else begin
                    state_d = REQ;
                end
            end
            REQ:  if (mem_gnt) state_d = WAIT;
            WAIT: if (mem_rvalid) begin
                state_d = RESP;
                data_d  = ext;
                sx_d    = ext_sx;
                err_d   = 1'b0;
            end
            default: if (res_ready) state_d = IDLE;
        endcase
`ifdef LSU_TIMEOUT_EN
        if (state_q == REQ || state_q == WAIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CW'(TIMEOUT_CYCLES)) begin
                state_d = RESP;
                data_d  = '0;
                sx_d    = SX_3100;
                err_d   = 1'b1;
            end
        end
`endif
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            f3_q    <= '0;
            data_q  <= '0;
            sx_q    <= SX_3100;
            err_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            data_q  <= data_d;
            sx_q    <= sx_d;
            err_q   <= err_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end
    assign ld_ready        = rst_n && state_q == IDLE;
    assign mem_req         = state_q == REQ;
    assign mem_addr        = mem_req ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign res_valid       = state_q == RESP;
    assign unextended_data = res_valid ? data_q : '0;
    assign sx_op           = res_valid ? sx_q : SX_3100;
    assign res_err         = res_valid && err_q;
endmodule
